// File: rtl/buffer_read_sequencer.sv
// buffer_read_sequencer: walks port B of every lane in lockstep, absorbs read latency,
// and hands one lane word per handshake to the serializers through a credit-limited FIFO
module buffer_read_sequencer #(
    parameter int BYTES_PER_BLOCK = 2250,
    parameter int BANK_COUNT = 6,
    parameter int BLOCK_COUNT = 2,
    parameter int READ_LATENCY = 2,
    parameter int LANES = BANK_COUNT * BLOCK_COUNT,
    parameter int AW = $clog2(BYTES_PER_BLOCK),
    parameter int FIFO_DEPTH = READ_LATENCY + 2
) (
    input  logic                  I_clk,
    input  logic                  I_reset,
    input  logic                  I_start,
    output logic                  O_busy,
    output logic                  O_done,
    output logic                  O_ceb,
    output logic [LANES*AW-1:0]   O_adb_flat,
    input  logic [LANES*8-1:0]    I_dout_flat,
    output logic [LANES*8-1:0]    O_data,
    output logic                  O_valid,
    input  logic                  I_ready,
    output logic                  O_last
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BYTES_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_n;
    logic [AW-1:0] addr;
    logic [READ_LATENCY-1:0] pipe_vld, pipe_lst;
    logic [LANES*8:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] fifo_count;
    logic credit_ok, issue, issue_last, push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // A read is only issued when a FIFO slot is reserved for it, counting reads still in flight
    always_comb begin
        credit_ok = int'(fifo_count) + $countones(pipe_vld) < FIFO_DEPTH;
        issue = state == READ && credit_ok;
        issue_last = issue && addr == LAST_ADDR;
        push = pipe_vld[READ_LATENCY-1];
        pop = O_valid && I_ready;
        state_n = state;
        case (state)
            IDLE:    state_n = I_start ? READ : IDLE;
            READ:    state_n = issue_last ? DRAIN : READ;
            DRAIN:   state_n = pop && O_last ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    assign O_busy = state == READ || state == DRAIN;
    assign O_done = state == DONE;
    assign O_ceb = issue;
    assign O_adb_flat = issue ? {LANES{addr}} : '0;
    assign O_valid = fifo_count != 0;
    assign {O_last, O_data} = O_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state <= IDLE;
            addr <= '0;
            pipe_vld <= '0;
            pipe_lst <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fifo_count <= '0;
        end else begin
            state <= state_n;
            addr <= state == IDLE ? '0 : issue && !issue_last ? addr + 1'b1 : addr;
            pipe_vld <= READ_LATENCY'({pipe_vld, issue});
            pipe_lst <= READ_LATENCY'({pipe_lst, issue_last});
            rd_ptr <= pop ? nxt(rd_ptr) : rd_ptr;
            wr_ptr <= push ? nxt(wr_ptr) : wr_ptr;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge I_clk) begin
        if (push) mem[wr_ptr] <= {pipe_lst[READ_LATENCY-1], I_dout_flat};
    end
endmodule

// File: tb/tb_buffer_read_sequencer.sv
// tb_buffer_read_sequencer: scoreboarded bench with a lane-tagged buffer model,
// covering free-run, backpressure, random ready, ignored start, reset and latency 1
module tb_buffer_read_sequencer;
    localparam int BPB = 8;
    localparam int LANES = 2;
    localparam int AW = 3;
    localparam int DW = LANES * 8;

    logic clk = 0, rst = 1, start = 0, ready = 0, start1 = 0, ready1 = 1;
    logic busy, done, ceb, valid, last, busy1, done1, ceb1, valid1, last1;
    logic [LANES*AW-1:0] adb, adb1, pa0, pa1, pb0;
    logic [DW-1:0] dout, data, dout1, data1;

    typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
    beat_t exp_q[$];
    beat_t e;
    int errors = 0, checks = 0, cyc = 0, t0 = 0, nb = 0, done_cnt = 0;
    bit rand_rdy = 0;

    buffer_read_sequencer #(.BYTES_PER_BLOCK(BPB), .BANK_COUNT(2), .BLOCK_COUNT(1), .READ_LATENCY(2)) dut (
        .I_clk(clk), .I_reset(rst), .I_start(start), .O_busy(busy), .O_done(done), .O_ceb(ceb),
        .O_adb_flat(adb), .I_dout_flat(dout), .O_data(data), .O_valid(valid), .I_ready(ready), .O_last(last));

    buffer_read_sequencer #(.BYTES_PER_BLOCK(BPB), .BANK_COUNT(2), .BLOCK_COUNT(1), .READ_LATENCY(1)) dut1 (
        .I_clk(clk), .I_reset(rst), .I_start(start1), .O_busy(busy1), .O_done(done1), .O_ceb(ceb1),
        .O_adb_flat(adb1), .I_dout_flat(dout1), .O_data(data1), .O_valid(valid1), .I_ready(ready1), .O_last(last1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (rand_rdy) begin #1; ready = 1'($urandom_range(0, 1)); end

    // Buffer model: lane i at address a returns {i, a}, each lane reading its own address
    function automatic logic [DW-1:0] mem_rd(input logic [LANES*AW-1:0] a);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*8+:8] = {4'(i), 1'b0, a[i*AW+:AW]};
        return r;
    endfunction

    always @(posedge clk) begin
        pa0 <= adb;
        pa1 <= pa0;
        pb0 <= adb1;
    end
    assign dout = mem_rd(pa1);
    assign dout1 = mem_rd(pb0);

    function automatic logic [DW-1:0] exp_word(input int a);
        logic [DW-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*8+:8] = 8'(16 * i + a);
        return w;
    endfunction

    function automatic logic [LANES*AW-1:0] rep(input int a);
        logic [LANES*AW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*AW+:AW] = AW'(a);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc - t0);
        end
    endtask

    task automatic pulse_start(input bit which, input bit expect_frame);
        @(posedge clk);
        #1;
        if (which) start1 = 1; else start = 1;
        t0 = cyc;
        if (expect_frame) for (int a = 0; a < BPB; a++) exp_q.push_back('{exp_word(a), a == BPB - 1});
        @(posedge clk);
        #1;
        start = 0;
        start1 = 0;
    endtask

    task automatic wait_done(input int budget);
        int at = -1;
        for (int k = 0; k < budget && at < 0; k++) begin
            @(negedge clk);
            if (done) at = cyc - t0;
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL done_timeout: no O_done within %0d cycles", budget);
        end
    endtask

    always @(negedge clk) begin
        if (rst) nb = 0;
        else begin
            if (valid && ready) begin
                checks++;
                nb++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: data=%h last=%b with empty scoreboard", data, last);
                end else begin
                    e = exp_q.pop_front();
                    if ({data, last} !== {e.d, e.l}) begin
                        errors++;
                        $display("FAIL beat: got data=%h last=%b expected data=%h last=%b", data, last, e.d, e.l);
                    end
                end
            end
            if (done) begin
                chk("frame_beats", nb, BPB);
                chk("queue_empty_at_done", exp_q.size(), 0);
                nb = 0;
                done_cnt++;
            end
            if (dut.push && dut.fifo_count == 4 && !(valid && ready)) begin
                checks++;
                errors++;
                $display("FAIL fifo_overflow: write into full FIFO");
            end
        end
    end

    initial begin
        int issued, stray, dc, first, doneat, k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, ceb, adb, data, valid, last}, 0);
        chk("reset_outputs_l1", {busy1, done1, ceb1, adb1, data1, valid1, last1}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        ready = 1;

        pulse_start(0, 1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("fr_ceb", ceb, c <= 8);
            if (c <= 8) chk("fr_addr", adb, rep(c - 1));
            chk("fr_valid", valid, c >= 4 && c <= 11);
            chk("fr_done", done, c == 12);
            chk("fr_busy", busy, c <= 11);
            if (c == 4) chk("fr_first_data", data, 16'h1000);
            if (c == 10) chk("fr_last_low", last, 0);
            if (c == 11) chk("fr_last_beat", {last, data}, {1'b1, 16'h1707});
        end

        @(posedge clk);
        #1;
        ready = 0;
        pulse_start(0, 1);
        issued = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ceb) begin
                chk("bp_addr", adb, rep(issued));
                issued++;
            end
            if (c >= 5) chk("bp_hold", {valid, data}, {1'b1, 16'h1000});
        end
        chk("bp_issue_count", issued, 4);
        @(posedge clk);
        #1;
        ready = 1;
        wait_done(60);

        rand_rdy = 1;
        for (int f = 0; f < 20; f++) begin
            pulse_start(0, 1);
            wait_done(300);
        end
        rand_rdy = 0;
        @(posedge clk);
        #1;
        ready = 1;

        dc = done_cnt;
        pulse_start(0, 1);
        @(posedge clk);
        #1;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        wait_done(60);
        repeat (20) @(negedge clk);
        chk("busy_start_one_done", done_cnt - dc, 1);
        chk("busy_start_no_extra", {busy, valid}, 0);

        pulse_start(0, 1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("midreset_outputs", {busy, done, ceb, adb, data, valid, last}, 0);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid || busy) stray++;
        end
        chk("midreset_no_stale", stray, 0);
        pulse_start(0, 1);
        @(negedge clk);
        chk("midreset_restart_addr", {ceb, adb}, {1'b1, rep(0)});
        wait_done(60);

        first = -1;
        doneat = -1;
        k = 0;
        pulse_start(1, 0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (valid1 && first < 0) first = c;
            if (valid1) begin
                chk("l1_beat", {last1, data1}, {k == BPB - 1, exp_word(k)});
                k++;
            end
            if (done1 && doneat < 0) doneat = c;
        end
        chk("l1_first_valid", first, 3);
        chk("l1_done", doneat, 11);
        chk("l1_beats", k, BPB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
